// File: rtl/pbus_pkg.sv
// ---------------------------------------------------------------------------
// pbus_pkg
// Shared definitions for the peripheral-bus arbiter slice.
//   - arbiter state encoding (kept as plain 2-bit constants so older
//     blocks that compare against raw values keep working)
//   - default bus widths for the 4 KB peripheral/config/SPM window
//   - default fairness limit
//   - helper that turns a state into the one-hot {m1,m0} grant vector
// No ports: package only.
// ---------------------------------------------------------------------------
package pbus_pkg;

    typedef logic [1:0] pbus_state_t;

    localparam pbus_state_t ST_IDLE = 2'd0;
    localparam pbus_state_t ST_GNT0 = 2'd1;
    localparam pbus_state_t ST_GNT1 = 2'd2;

    localparam int PBUS_ADDR_W    = 12;
    localparam int PBUS_DATA_W    = 8;
    localparam int PBUS_MAX_BEATS = 8;

    // One-hot grant as seen on the gnt port: bit 1 = master 1, bit 0 = master 0.
    function automatic logic [1:0] state_to_gnt(input pbus_state_t st);
        logic [1:0] g;
        g    = 2'b00;
        g[0] = (st == ST_GNT0);
        g[1] = (st == ST_GNT1);
        return g;
    endfunction

endpackage

// File: rtl/pbus_rr_pick.sv
// ---------------------------------------------------------------------------
// pbus_rr_pick
// Two-way round-robin picker. Given the pair of requests and which master
// won last time, returns a one-hot pick. A lone requester always wins; on a
// tie the master that did not win last time is chosen. No requests -> 00.
//
// Ports
//   req      in  2  request pair {m1,m0}
//   last_m1  in  1  1 = master 1 was the last winner, 0 = master 0
//   pick     out 2  one-hot pick {m1,m0}, 00 when nobody requests
// ---------------------------------------------------------------------------
module pbus_rr_pick (
    input  logic [1:0] req,
    input  logic       last_m1,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last_m1 ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/pbus_arbiter.sv
// ---------------------------------------------------------------------------
// pbus_arbiter
// Two-master Wishbone classic arbiter and ACK generator for the 4 KB
// peripheral/config/SPM window. Master 0 is the CPU data port, master 1 the
// optional DMA engine. The slaves behind this block never drive ACK, so every
// beat is acknowledged here exactly one cycle after it is strobed, with the
// slave read data captured on the same edge.
//
// Grants are sticky for the length of a CYC. On release the other master is
// served directly if it is waiting. While one master holds the bus and the
// other waits, acked beats are counted; once MAX_BEATS have been acked the
// holder is stalled and the bus moves to the waiting master.
//
// Ports
//   clk                     in   1       core clock
//   rst                     in   1       asynchronous reset, active low
//   m0_WB_ADRi/DATi/WEi     in           master 0 address / write data / WE
//   m0_WB_CYCi/STBi         in   1       master 0 cycle / strobe
//   m0_WB_DATo              out  DATA_W  master 0 read data (registered)
//   m0_WB_ACKo              out  1       master 0 acknowledge
//   m1_WB_*                              same set for master 1
//   s_WB_ADRo/DATo/WEo      out          slave address / write data / WE
//   s_WB_CYCo/STBo          out  1       slave cycle / strobe
//   s_WB_DATi               in   DATA_W  slave read data
//   gnt                     out  2       one-hot current grant {m1,m0}
// ---------------------------------------------------------------------------
module pbus_arbiter
    import pbus_pkg::*;
#(
    parameter int ADDR_W    = PBUS_ADDR_W,
    parameter int DATA_W    = PBUS_DATA_W,
    parameter int MAX_BEATS = PBUS_MAX_BEATS,
    parameter bit M1_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_WB_ADRi,
    input  logic [DATA_W-1:0] m0_WB_DATi,
    output logic [DATA_W-1:0] m0_WB_DATo,
    input  logic              m0_WB_WEi,
    input  logic              m0_WB_CYCi,
    input  logic              m0_WB_STBi,
    output logic              m0_WB_ACKo,

    input  logic [ADDR_W-1:0] m1_WB_ADRi,
    input  logic [DATA_W-1:0] m1_WB_DATi,
    output logic [DATA_W-1:0] m1_WB_DATo,
    input  logic              m1_WB_WEi,
    input  logic              m1_WB_CYCi,
    input  logic              m1_WB_STBi,
    output logic              m1_WB_ACKo,

    output logic [ADDR_W-1:0] s_WB_ADRo,
    output logic [DATA_W-1:0] s_WB_DATo,
    input  logic [DATA_W-1:0] s_WB_DATi,
    output logic              s_WB_WEo,
    output logic              s_WB_CYCo,
    output logic              s_WB_STBo,

    output logic [1:0]        gnt
);

    localparam logic [7:0] MAX_BEATS_C = 8'(MAX_BEATS);

    pbus_state_t       state_r;
    pbus_state_t       state_nxt;
    logic              last_m1_r;
    logic [7:0]        beat_cnt_r;
    logic              ack_r;
    logic [DATA_W-1:0] m0_dat_r;
    logic [DATA_W-1:0] m1_dat_r;

    logic              m0_req;
    logic              m1_req;
    logic [1:0]        pick;
    logic              gnt0;
    logic              gnt1;
    logic              other_req;
    logic              stall;
    logic              beat_start;

    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_dat;
    logic              sel_we;
    logic              sel_cyc;
    logic              sel_stb;

    // With master 1 disabled its CYC is ignored everywhere, so GNT1 can
    // never be reached and master 1 never blocks or delays master 0.
    assign m0_req = m0_WB_CYCi;
    assign m1_req = M1_EN & m1_WB_CYCi;

    assign gnt0 = (state_r == ST_GNT0);
    assign gnt1 = (state_r == ST_GNT1);
    assign gnt  = state_to_gnt(state_r);

    pbus_rr_pick u_rr_pick (
        .req     ({m1_req, m0_req}),
        .last_m1 (last_m1_r),
        .pick    (pick)
    );

    // Whether the master that is not holding the bus is waiting for it.
    // The fairness counter only means something while this is true.
    always_comb begin
        other_req = 1'b0;
        if (gnt0) begin
            other_req = m1_req;
        end else if (gnt1) begin
            other_req = m0_req;
        end
    end

    assign stall = (beat_cnt_r == MAX_BEATS_C);

    // Route the granted master onto the slave side; nothing granted means
    // an all-zero slave bus. STB also needs the master's CYC so that a
    // master abandoning its cycle cannot start a beat on the way out.
    always_comb begin
        sel_adr = '0;
        sel_dat = '0;
        sel_we  = 1'b0;
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        if (gnt0) begin
            sel_adr = m0_WB_ADRi;
            sel_dat = m0_WB_DATi;
            sel_we  = m0_WB_WEi;
            sel_cyc = m0_WB_CYCi;
            sel_stb = m0_WB_STBi;
        end else if (gnt1) begin
            sel_adr = m1_WB_ADRi;
            sel_dat = m1_WB_DATi;
            sel_we  = m1_WB_WEi;
            sel_cyc = m1_WB_CYCi;
            sel_stb = m1_WB_STBi;
        end
    end

    // A pending ACK masks STB so each beat occupies two cycles; the stall
    // mask stops the holder from starting anything once it has used up
    // its share while the other master waits.
    assign s_WB_ADRo  = sel_adr;
    assign s_WB_DATo  = sel_dat;
    assign s_WB_WEo   = sel_we;
    assign s_WB_CYCo  = sel_cyc;
    assign s_WB_STBo  = sel_stb & sel_cyc & ~ack_r & ~stall;
    assign beat_start = s_WB_CYCo & s_WB_STBo;

    assign m0_WB_ACKo = ack_r & gnt0;
    assign m1_WB_ACKo = ack_r & gnt1 & M1_EN;
    assign m0_WB_DATo = m0_dat_r;
    assign m1_WB_DATo = m1_dat_r;

    // Grant state machine. No transition is taken while an ACK is pending,
    // so the ACK always lands on the master that issued the beat. When the
    // holder lets go (or is stalled out) the waiting master is granted in
    // the same step rather than passing through IDLE.
    always_comb begin
        state_nxt = state_r;
        if (!ack_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (pick[0]) begin
                        state_nxt = ST_GNT0;
                    end else if (pick[1]) begin
                        state_nxt = ST_GNT1;
                    end
                end
                ST_GNT0: begin
                    if (!m0_req || (stall && m1_req)) begin
                        state_nxt = m1_req ? ST_GNT1 : ST_IDLE;
                    end
                end
                ST_GNT1: begin
                    if (!m1_req || (stall && m0_req)) begin
                        state_nxt = m0_req ? ST_GNT0 : ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and round-robin history. After reset master 1 counts as the
    // last winner so master 0 takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            last_m1_r <= 1'b1;
        end else begin
            state_r <= state_nxt;
            if (state_nxt != state_r) begin
                if (state_nxt == ST_GNT0) begin
                    last_m1_r <= 1'b0;
                end else if (state_nxt == ST_GNT1) begin
                    last_m1_r <= 1'b1;
                end
            end
        end
    end

    // Fairness counter: counts ACKs delivered to the holder while the other
    // master is waiting. It saturates at the limit (which raises stall) and
    // restarts whenever the grant moves or the other master stops waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_r <= 8'd0;
        end else if ((state_nxt != state_r) || !other_req) begin
            beat_cnt_r <= 8'd0;
        end else if (ack_r && !stall) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
        end
    end

    // ACK generation and read-data capture. A strobed beat is acked on the
    // next edge, and for reads the slave data is latched for the issuing
    // master on that same edge. Each master keeps its last captured value
    // while it is not being served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_r    <= 1'b0;
            m0_dat_r <= '0;
            m1_dat_r <= '0;
        end else begin
            ack_r <= beat_start;
            if (beat_start && !s_WB_WEo) begin
                if (gnt0) begin
                    m0_dat_r <= s_WB_DATi;
                end
                if (gnt1) begin
                    m1_dat_r <= s_WB_DATi;
                end
            end
        end
    end

endmodule

// File: tb/tb_pbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pbus_arbiter
// Directed bench for pbus_arbiter. A main instance (M1_EN=1, MAX_BEATS=8)
// is driven from a vector table plus hand-written multi-cycle sequences; a
// second instance with M1_EN=0 shares master 0 and the slave data but has
// master 1 permanently requesting.
// ---------------------------------------------------------------------------
module tb_pbus_arbiter;

    typedef struct {
        logic        pre_reset;
        logic        m0_cyc;
        logic        m0_stb;
        logic        m0_we;
        logic [11:0] m0_adr;
        logic [7:0]  m0_dat;
        logic        m1_cyc;
        logic        m1_stb;
        logic        m1_we;
        logic [11:0] m1_adr;
        logic [7:0]  s_dat;
        logic [1:0]  exp_gnt;
        logic        exp_s_stb;
        logic [11:0] exp_s_adr;
        logic        exp_m0_ack;
        logic        exp_m1_ack;
        logic [7:0]  exp_m0_do;
        logic [7:0]  exp_m1_do;
    } vec_t;

    logic        clk;
    logic        rst;

    logic [11:0] m0_adr;
    logic [7:0]  m0_dat;
    logic        m0_we;
    logic        m0_cyc;
    logic        m0_stb;
    logic [11:0] m1_adr;
    logic [7:0]  m1_dat;
    logic        m1_we;
    logic        m1_cyc;
    logic        m1_stb;
    logic [7:0]  s_dat;

    logic [7:0]  m0_do;
    logic [7:0]  m1_do;
    logic        m0_ack;
    logic        m1_ack;
    logic [11:0] s_adr;
    logic [7:0]  s_do;
    logic        s_we;
    logic        s_cyc;
    logic        s_stb;
    logic [1:0]  gnt;

    logic [7:0]  d2_m0_do;
    logic [7:0]  d2_m1_do;
    logic        d2_m0_ack;
    logic        d2_m1_ack;
    logic [11:0] d2_s_adr;
    logic [7:0]  d2_s_do;
    logic        d2_s_we;
    logic        d2_s_cyc;
    logic        d2_s_stb;
    logic [1:0]  d2_gnt;
    logic        d2_m1_cyc;
    logic        d2_m1_stb;

    int          checks;
    int          errors;
    logic        mon_en;
    vec_t        vecs[$];

    pbus_arbiter #(
        .ADDR_W    (12),
        .DATA_W    (8),
        .MAX_BEATS (8),
        .M1_EN     (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_WB_ADRi (m0_adr),
        .m0_WB_DATi (m0_dat),
        .m0_WB_DATo (m0_do),
        .m0_WB_WEi  (m0_we),
        .m0_WB_CYCi (m0_cyc),
        .m0_WB_STBi (m0_stb),
        .m0_WB_ACKo (m0_ack),
        .m1_WB_ADRi (m1_adr),
        .m1_WB_DATi (m1_dat),
        .m1_WB_DATo (m1_do),
        .m1_WB_WEi  (m1_we),
        .m1_WB_CYCi (m1_cyc),
        .m1_WB_STBi (m1_stb),
        .m1_WB_ACKo (m1_ack),
        .s_WB_ADRo  (s_adr),
        .s_WB_DATo  (s_do),
        .s_WB_DATi  (s_dat),
        .s_WB_WEo   (s_we),
        .s_WB_CYCo  (s_cyc),
        .s_WB_STBo  (s_stb),
        .gnt        (gnt)
    );

    pbus_arbiter #(
        .ADDR_W    (12),
        .DATA_W    (8),
        .MAX_BEATS (8),
        .M1_EN     (1'b0)
    ) dut_nom1 (
        .clk        (clk),
        .rst        (rst),
        .m0_WB_ADRi (m0_adr),
        .m0_WB_DATi (m0_dat),
        .m0_WB_DATo (d2_m0_do),
        .m0_WB_WEi  (m0_we),
        .m0_WB_CYCi (m0_cyc),
        .m0_WB_STBi (m0_stb),
        .m0_WB_ACKo (d2_m0_ack),
        .m1_WB_ADRi (12'h3FF),
        .m1_WB_DATi (8'h00),
        .m1_WB_DATo (d2_m1_do),
        .m1_WB_WEi  (1'b0),
        .m1_WB_CYCi (d2_m1_cyc),
        .m1_WB_STBi (d2_m1_stb),
        .m1_WB_ACKo (d2_m1_ack),
        .s_WB_ADRo  (d2_s_adr),
        .s_WB_DATo  (d2_s_do),
        .s_WB_DATi  (s_dat),
        .s_WB_WEo   (d2_s_we),
        .s_WB_CYCo  (d2_s_cyc),
        .s_WB_STBo  (d2_s_stb),
        .gnt        (d2_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // The M1_EN=0 instance must never grant or acknowledge master 1,
    // whatever the shared master 0 is doing.
    always @(negedge clk) begin
        if (mon_en) begin
            check_output("nom1_gnt1", {31'd0, d2_gnt[1]}, 32'd0);
            check_output("nom1_m1_ack", {31'd0, d2_m1_ack}, 32'd0);
        end
    end

    task automatic idle_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic add_vec(
        input logic pre, input logic c0, input logic s0, input logic w0,
        input logic [11:0] a0, input logic [7:0] d0,
        input logic c1, input logic s1, input logic w1, input logic [11:0] a1,
        input logic [7:0] sd, input logic [1:0] eg, input logic es,
        input logic [11:0] ea, input logic ek0, input logic ek1,
        input logic [7:0] ed0, input logic [7:0] ed1);
        vec_t v;
        v.pre_reset = pre; v.m0_cyc = c0; v.m0_stb = s0; v.m0_we = w0;
        v.m0_adr = a0; v.m0_dat = d0; v.m1_cyc = c1; v.m1_stb = s1;
        v.m1_we = w1; v.m1_adr = a1; v.s_dat = sd; v.exp_gnt = eg;
        v.exp_s_stb = es; v.exp_s_adr = ea; v.exp_m0_ack = ek0;
        v.exp_m1_ack = ek1; v.exp_m0_do = ed0; v.exp_m1_do = ed1;
        vecs.push_back(v);
    endtask

    // Drive one vector just after the rising edge, then compare at the
    // falling edge of the same cycle.
    task automatic apply_stimulus(input vec_t v);
        if (v.pre_reset) begin
            reset_dut();
        end
        @(posedge clk);
        #1;
        m0_cyc = v.m0_cyc; m0_stb = v.m0_stb; m0_we = v.m0_we;
        m0_adr = v.m0_adr; m0_dat = v.m0_dat;
        m1_cyc = v.m1_cyc; m1_stb = v.m1_stb; m1_we = v.m1_we;
        m1_adr = v.m1_adr; m1_dat = 8'h00;
        s_dat  = v.s_dat;
        @(negedge clk);
    endtask

    initial begin
        int          k;
        int          r;
        int          m0_acks;
        logic        seen_g1;
        logic        done;
        logic [11:0] cm_adr[$];
        logic [7:0]  cm_dat[$];

        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        d2_m1_cyc = 1'b1;
        d2_m1_stb = 1'b1;
        s_dat     = 8'h00;
        reset_dut();

        check_output("reset_gnt", {30'd0, gnt}, 32'd0);
        check_output("reset_s_cyc", {31'd0, s_cyc}, 32'd0);
        check_output("reset_m0_do", {24'd0, m0_do}, 32'd0);
        mon_en = 1'b1;

        // Single m0 read at 0x6F3 returning 0xA5.
        add_vec(0, 1,1,0,12'h6F3,8'h00, 0,0,0,12'h000, 8'hA5, 2'b00,0,12'h000,0,0,8'h00,8'h00);
        add_vec(0, 1,1,0,12'h6F3,8'h00, 0,0,0,12'h000, 8'hA5, 2'b01,1,12'h6F3,0,0,8'h00,8'h00);
        add_vec(0, 1,1,0,12'h6F3,8'h00, 0,0,0,12'h000, 8'hA5, 2'b01,0,12'h6F3,1,0,8'hA5,8'h00);
        add_vec(0, 0,0,0,12'h000,8'h00, 0,0,0,12'h000, 8'hA5, 2'b01,0,12'h000,0,0,8'hA5,8'h00);
        add_vec(0, 0,0,0,12'h000,8'h00, 0,0,0,12'h000, 8'hA5, 2'b00,0,12'h000,0,0,8'hA5,8'h00);
        // m0 abandons a write (CYC drops with STB high) before any ACK.
        add_vec(0, 1,1,1,12'h100,8'h3C, 0,0,0,12'h000, 8'h00, 2'b00,0,12'h000,0,0,8'hA5,8'h00);
        add_vec(0, 0,1,1,12'h100,8'h3C, 0,0,0,12'h000, 8'h00, 2'b01,0,12'h100,0,0,8'hA5,8'h00);
        add_vec(0, 0,0,0,12'h000,8'h00, 0,0,0,12'h000, 8'h00, 2'b00,0,12'h000,0,0,8'hA5,8'h00);
        // Tie straight after reset: m0 first, then m1 directly on release.
        add_vec(1, 1,1,0,12'h010,8'h00, 1,1,0,12'h020, 8'h5A, 2'b00,0,12'h000,0,0,8'h00,8'h00);
        add_vec(0, 1,1,0,12'h010,8'h00, 1,1,0,12'h020, 8'h5A, 2'b01,1,12'h010,0,0,8'h00,8'h00);
        add_vec(0, 1,1,0,12'h010,8'h00, 1,1,0,12'h020, 8'h5A, 2'b01,0,12'h010,1,0,8'h5A,8'h00);
        add_vec(0, 0,0,0,12'h000,8'h00, 1,1,0,12'h020, 8'h5A, 2'b01,0,12'h000,0,0,8'h5A,8'h00);
        add_vec(0, 0,0,0,12'h000,8'h00, 1,1,0,12'h020, 8'h77, 2'b10,1,12'h020,0,0,8'h5A,8'h00);
        add_vec(0, 0,0,0,12'h000,8'h00, 1,1,0,12'h020, 8'h77, 2'b10,0,12'h020,0,1,8'h5A,8'h77);
        add_vec(0, 0,0,0,12'h000,8'h00, 0,0,0,12'h000, 8'h77, 2'b10,0,12'h000,0,0,8'h5A,8'h77);
        add_vec(0, 0,0,0,12'h000,8'h00, 0,0,0,12'h000, 8'h77, 2'b00,0,12'h000,0,0,8'h5A,8'h77);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("v%0d_gnt", i), {30'd0, gnt}, {30'd0, vecs[i].exp_gnt});
            check_output($sformatf("v%0d_s_stb", i), {31'd0, s_stb}, {31'd0, vecs[i].exp_s_stb});
            check_output($sformatf("v%0d_s_adr", i), {20'd0, s_adr}, {20'd0, vecs[i].exp_s_adr});
            check_output($sformatf("v%0d_m0_ack", i), {31'd0, m0_ack}, {31'd0, vecs[i].exp_m0_ack});
            check_output($sformatf("v%0d_m1_ack", i), {31'd0, m1_ack}, {31'd0, vecs[i].exp_m1_ack});
            check_output($sformatf("v%0d_m0_do", i), {24'd0, m0_do}, {24'd0, vecs[i].exp_m0_do});
            check_output($sformatf("v%0d_m1_do", i), {24'd0, m1_do}, {24'd0, vecs[i].exp_m1_do});
            if (!vecs[i].m1_cyc && vecs[i].exp_gnt != 2'b10) begin
                check_output($sformatf("v%0d_nom1_gnt", i), {30'd0, d2_gnt}, {30'd0, vecs[i].exp_gnt});
                check_output($sformatf("v%0d_nom1_m0_ack", i), {31'd0, d2_m0_ack}, {31'd0, vecs[i].exp_m0_ack});
                check_output($sformatf("v%0d_nom1_m0_do", i), {24'd0, d2_m0_do}, {24'd0, vecs[i].exp_m0_do});
            end
        end

        // Fairness: m0 streams 20 writes while m1 wants two reads.
        reset_dut();
        k       = 0;
        r       = 0;
        m0_acks = 0;
        seen_g1 = 1'b0;
        done    = 1'b0;
        s_dat   = 8'hC3;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (k < 20) begin
                m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
                m0_adr = 12'h200 + 12'(k); m0_dat = 8'(k * 3 + 1);
            end else begin
                m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
            end
            if (r < 2) begin
                m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 12'h300;
            end else begin
                m1_cyc = 1'b0; m1_stb = 1'b0;
            end
            @(negedge clk);
            if (s_stb && s_we) begin
                cm_adr.push_back(s_adr);
                cm_dat.push_back(s_do);
            end
            check_output("fair_both_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (m0_ack) begin
                k++;
                m0_acks++;
            end
            if (m1_ack) begin
                r++;
            end
            if (!seen_g1 && gnt == 2'b10) begin
                seen_g1 = 1'b1;
                check_output("fair_m0_acks_before_m1", m0_acks, 32'd8);
            end
            if (k == 20 && r == 2) begin
                done = 1'b1;
                break;
            end
        end
        check_output("fair_m1_granted", {31'd0, seen_g1}, 32'd1);
        check_output("fair_done", {31'd0, done}, 32'd1);
        check_output("fair_commit_count", cm_adr.size(), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < cm_adr.size()) begin
                check_output($sformatf("fair_commit%0d_adr", i), {20'd0, cm_adr[i]}, 32'h200 + i);
                check_output($sformatf("fair_commit%0d_dat", i), {24'd0, cm_dat[i]}, (i * 3 + 1) & 32'hFF);
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(posedge clk);

        // Asynchronous reset during a strobed m1 beat; m1_do still holds
        // the data captured during the fairness run.
        #1;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 12'h0AB;
        s_dat  = 8'h99;
        @(posedge clk);
        #1;
        check_output("rst_pre_gnt", {30'd0, gnt}, 32'h2);
        check_output("rst_pre_s_stb", {31'd0, s_stb}, 32'd1);
        check_output("rst_pre_m1_do", {24'd0, m1_do}, 32'hC3);
        #1;
        rst = 1'b0;
        #1;
        check_output("rst_async_gnt", {30'd0, gnt}, 32'd0);
        check_output("rst_async_s_cyc", {31'd0, s_cyc}, 32'd0);
        check_output("rst_async_s_stb", {31'd0, s_stb}, 32'd0);
        check_output("rst_async_s_adr", {20'd0, s_adr}, 32'd0);
        check_output("rst_async_m1_do", {24'd0, m1_do}, 32'd0);
        check_output("rst_async_m1_ack", {31'd0, m1_ack}, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        check_output("rst_ack_lost", {31'd0, m1_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 12'h011;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 12'h022;
        @(negedge clk);
        check_output("rst_tie_idle_gnt", {30'd0, gnt}, 32'd0);
        @(negedge clk);
        check_output("rst_tie_gnt", {30'd0, gnt}, 32'd1);
        check_output("rst_tie_s_adr", {20'd0, s_adr}, 32'h011);
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
